instruction_encoder: RTL and testbench

// - Inverse of the fetch-side field decoder: packs RV32I fields (opcode, funct3/7, rd, rs1, rs2, imm) into 32-bit words.
// - Streams encoded words with sequential word addresses to an instruction-memory write port.
// - Used by the self-test program loader and by the bench to build IMEM images in-system.
// - Registered, valid/ready on both sides, 1-entry output buffer, fill counter with full stop.

---
 rtl/instruction_encoder_pkg.sv | 67 ++++++
 rtl/instruction_encoder_if.sv | 36 +++
 rtl/instruction_encoder_inst_pack.sv | 47 ++++
 rtl/instruction_encoder.sv | 117 +++++++++++
 tb/tb_instruction_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared opcode constants, format/state enums and immediate range helpers for the RV32I encoder.
// The immediate check helpers are only referenced when IMM_RANGE_CHECK_EN is defined.
package rv_encode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HOLD,
        ST_FULL
    } enc_state_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OP_R:                                 fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
            OP_STORE:                             fmt = FMT_S;
            OP_BRANCH:                            fmt = FMT_B;
            OP_LUI, OP_AUIPC:                     fmt = FMT_U;
            OP_JAL:                               fmt = FMT_J;
            default:                              fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

    // True when every bit above the sign bit of a 'bits'-wide field equals that sign bit.
    function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
        logic [31:0] hi;
        hi = 32'($signed(imm) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

    function automatic logic imm_out_of_range(input fmt_e fmt, input logic is_shift,
                                              input logic [31:0] imm);
        logic bad;
        case (fmt)
            FMT_I:   bad = is_shift ? (imm[31:5] != '0) : !fits_signed(imm, 12);
            FMT_S:   bad = !fits_signed(imm, 12);
            FMT_B:   bad = !fits_signed(imm, 13) || imm[0];
            FMT_U:   bad = (imm[11:0] != '0);
            FMT_J:   bad = !fits_signed(imm, 21) || imm[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-bundle input, memory-write output and status signals of the instruction encoder.
// slave is the encoder's view, master is the loader/memory side.
interface instruction_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              illegal;
    logic              imm_err;

    modport slave (
        input  clear, in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_inst, out_addr, count, full, illegal, imm_err
    );

    modport master (
        output clear, in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_inst, out_addr, count, full, illegal, imm_err
    );
endinterface

// File: rtl/instruction_encoder_inst_pack.sv
// Combinational RV32I field packer: opcode selects the format, fields are placed into the word.
// imm_bad is driven only when IMM_RANGE_CHECK_EN is defined; otherwise it is tied low.
module inst_pack
    import rv_encode_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output fmt_e        o_fmt,
    output logic [31:0] o_word,
    output logic        o_imm_bad
);

    logic w_shift;

    assign o_fmt   = opcode_fmt(i_opcode);
    assign w_shift = (i_opcode == OP_IMM) && ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

    always_comb begin
        // NOTE: default assigned before the case so every path drives o_word and no latch is inferred.
        o_word = '0;
        unique case (o_fmt)
            FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: begin
                if (w_shift) o_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                else         o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
            FMT_U: o_word = {i_imm[31:12], i_rd, i_opcode};
            FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            default: o_word = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    assign o_imm_bad = imm_out_of_range(o_fmt, w_shift, i_imm);
`else
    assign o_imm_bad = 1'b0;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs field bundles into words and streams them with sequential
// word addresses through a 1-entry output buffer; optional immediate check via IMM_RANGE_CHECK_EN.
module instruction_encoder
    import rv_encode_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    fmt_e              w_fmt;
    logic [31:0]       w_word;
    logic              w_imm_bad;

    enc_state_e        r_state;
    enc_state_e        w_next;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_illegal;
    logic              r_imm_err;

    logic              w_out_valid;
    logic              w_room;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_handoff;
    logic              w_emit;
    logic              w_last;

    inst_pack u_pack (
        .i_opcode  (bus.in_opcode),
        .i_funct3  (bus.in_funct3),
        .i_funct7  (bus.in_funct7),
        .i_rd      (bus.in_rd),
        .i_rs1     (bus.in_rs1),
        .i_rs2     (bus.in_rs2),
        .i_imm     (bus.in_imm),
        .o_fmt     (w_fmt),
        .o_word    (w_word),
        .o_imm_bad (w_imm_bad)
    );

    assign w_out_valid = (r_state == ST_HOLD);
    // A held word already claims one slot, so it counts against DEPTH before it is handed off.
    assign w_room      = ({1'b0, r_count} + (ADDR_W + 2)'(w_out_valid)) < {1'b0, DEPTH_C};
    assign w_in_ready  = !bus.clear && (!w_out_valid || bus.out_ready) && w_room;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_handoff   = !bus.clear && w_out_valid && bus.out_ready;
    assign w_emit      = w_accept && (w_fmt != FMT_ILL) && !w_imm_bad;
    assign w_last      = (r_count == DEPTH_C - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.clear) begin
            w_next = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_emit) w_next = ST_HOLD;
                ST_HOLD: begin
                    if (w_handoff) begin
                        if (w_last)       w_next = ST_FULL;
                        else if (!w_emit) w_next = ST_EMPTY;
                    end
                end
                ST_FULL:  w_next = ST_FULL;
                default:  w_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the same pre-edge values.
        if (!rst_n) begin
            r_inst    <= '0;
            r_addr    <= BASE;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_imm_err <= 1'b0;
        end else if (bus.clear) begin
            r_addr    <= BASE;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_imm_err <= 1'b0;
        end else begin
            if (w_handoff) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count + 1'b1;
            end
            if (w_emit) r_inst <= w_word;
            r_illegal <= w_accept && (w_fmt == FMT_ILL);
            r_imm_err <= w_accept && (w_fmt != FMT_ILL) && w_imm_bad;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_inst  = r_inst;
    assign bus.out_addr  = r_addr;
    assign bus.count     = r_count;
    assign bus.full      = (r_count == DEPTH_C);
    assign bus.illegal   = r_illegal;
    assign bus.imm_err   = r_imm_err;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed RV32I vectors, stall/full/clear/illegal
// cases, then randomized traffic against a cycle-level reference model.
module tb_instruction_encoder;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 14;
    localparam int DEPTH     = 4;
    localparam int ADDR_MOD  = 1 << ADDR_W;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bundle_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid;
    logic [31:0] m_inst;
    int          m_count;
    int          m_addr;
    bit          m_ill;
    bit          m_ierr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 illegal
    function automatic int ref_fmt(input logic [6:0] op);
        case (op)
            7'h33:                      return 0;
            7'h13, 7'h03, 7'h67, 7'h73: return 1;
            7'h23:                      return 2;
            7'h63:                      return 3;
            7'h37, 7'h17:               return 4;
            7'h6F:                      return 5;
            default:                    return 6;
        endcase
    endfunction

    function automatic bit is_shift(input bundle_t b);
        return (b.op == 7'h13) && ((b.f3 == 3'd1) || (b.f3 == 3'd5));
    endfunction

    function automatic bit ref_bad(input bundle_t b);
        longint s;
        s = longint'($signed(b.imm));
        case (ref_fmt(b.op))
            1: begin
                if (is_shift(b)) return b.imm > 32'd31;
                return (s < -2048) || (s > 2047);
            end
            2: return (s < -2048) || (s > 2047);
            3: return (s < -4096) || (s > 4095) || (s % 2 != 0);
            4: return (b.imm % 32'd4096) != 0;
            5: return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1) || (s % 2 != 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input bundle_t b);
        logic [31:0] u;
        logic [31:0] base;
        u    = b.imm;
        base = 32'(b.op);
        case (ref_fmt(b.op))
            0: return (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                      | (32'(b.f3) << 12) | (32'(b.rd) << 7) | base;
            1: begin
                if (is_shift(b))
                    return (32'(b.f7) << 25) | ((u % 32) << 20) | (32'(b.rs1) << 15)
                           | (32'(b.f3) << 12) | (32'(b.rd) << 7) | base;
                return ((u % 4096) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
                       | (32'(b.rd) << 7) | base;
            end
            2: return (((u / 32) % 128) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                      | (32'(b.f3) << 12) | ((u % 32) << 7) | base;
            3: return (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (32'(b.rs2) << 20)
                      | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | (((u / 2) % 16) << 8)
                      | (((u / 2048) % 2) << 7) | base;
            4: return ((u / 4096) << 12) | (32'(b.rd) << 7) | base;
            5: return (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21)
                      | (((u / 2048) % 2) << 20) | (((u / 4096) % 256) << 12)
                      | (32'(b.rd) << 7) | base;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bundle_t b;
        b.op = op; b.f3 = f3; b.f7 = 7'd0; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        return b;
    endfunction

    function automatic bundle_t gen();
        bundle_t b;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: b.op = 7'h33;  1: b.op = 7'h13;  2: b.op = 7'h03;  3: b.op = 7'h67;
            4: b.op = 7'h73;  5: b.op = 7'h23;  6: b.op = 7'h63;  7: b.op = 7'h37;
            8: b.op = 7'h17;  9: b.op = 7'h6F;  default: b.op = 7'($urandom);
        endcase
        b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        if ($urandom_range(0, 4) == 0) begin
            b.imm = $urandom;
        end else begin
            case (ref_fmt(b.op))
                1: b.imm = is_shift(b) ? (r % 32) : 32'($signed($urandom_range(0, 4095)) - 2048);
                2: b.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
                3: b.imm = 32'($signed($urandom_range(0, 4095)) * 2 - 4096);
                4: b.imm = (r / 4096) * 4096;
                5: b.imm = 32'($signed($urandom_range(0, 1048575)) * 2 - 1048576);
                default: b.imm = r;
            endcase
        end
        return b;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_inst = 32'd0; m_count = 0; m_addr = BASE_ADDR; m_ill = 1'b0; m_ierr = 1'b0;
    endtask

    // Drive one cycle at the negedge, compare all outputs to the model, then advance the model.
    task automatic step(input bit v, input bundle_t b, input bit ordy, input bit clr);
        bit exp_ready;
        bit acc;
        bit bad;
        int k;
        bus.in_valid = v; bus.in_opcode = b.op; bus.in_funct3 = b.f3; bus.in_funct7 = b.f7;
        bus.in_rd = b.rd; bus.in_rs1 = b.rs1; bus.in_rs2 = b.rs2; bus.in_imm = b.imm;
        bus.out_ready = ordy; bus.clear = clr;
        #1;
        exp_ready = !clr && (!m_valid || ordy) && (m_count + int'(m_valid) < DEPTH);
        check("in_ready", bus.in_ready, exp_ready);
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid) check("out_inst", bus.out_inst, m_inst);
        check("out_addr", bus.out_addr, m_addr);
        check("count", bus.count, m_count);
        check("full", bus.full, m_count == DEPTH);
        check("illegal", bus.illegal, m_ill);
        check("imm_err", bus.imm_err, m_ierr);
        if (clr) begin
            model_reset();
        end else begin
            acc = v && exp_ready;
            k   = ref_fmt(b.op);
            bad = RANGE_CHK && (k != 6) && ref_bad(b);
            if (m_valid && ordy) begin
                m_count++;
                m_addr  = (m_addr + 1) % ADDR_MOD;
                m_valid = 1'b0;
            end
            m_ill  = acc && (k == 6);
            m_ierr = acc && bad;
            if (acc && (k != 6) && !bad) begin
                m_valid = 1'b1;
                m_inst  = ref_word(b);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bundle_t addi, add, sw, beq, jal, lui, bad_op, big, idle;
        addi   = mk(7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        add    = mk(7'h33, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        sw     = mk(7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
        beq    = mk(7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
        jal    = mk(7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        lui    = mk(7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        bad_op = mk(7'h7F, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        big    = mk(7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
        idle   = mk(7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);

        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        model_reset();

        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_inst", bus.out_inst, 0);
        check("rst_out_addr", bus.out_addr, BASE_ADDR);
        check("rst_count", bus.count, 0);
        check("rst_full", bus.full, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_imm_err", bus.imm_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference vectors, filling DEPTH=4 with address wrap 14,15,0,1
        step(1, addi, 0, 0);
        check("addi_word", bus.out_inst, 32'h00500093);
        check("addi_addr", bus.out_addr, 14);
        step(1, add, 1, 0);
        check("add_word", bus.out_inst, 32'h002081B3);
        check("add_addr", bus.out_addr, 15);
        step(1, sw, 1, 0);
        check("sw_word", bus.out_inst, 32'h0020A423);
        check("sw_addr_wrap", bus.out_addr, 0);
        step(1, beq, 1, 0);
        check("beq_word", bus.out_inst, 32'hFE208EE3);
        check("beq_addr", bus.out_addr, 1);
        step(0, idle, 1, 0);
        check("full_flag", bus.full, 1);
        check("full_count", bus.count, 4);
        check("full_in_ready", bus.in_ready, 0);
        step(1, jal, 1, 0);
        check("full_no_accept", bus.out_valid, 0);
        check("full_count_hold", bus.count, 4);
        step(0, idle, 0, 1);
        check("clear_count", bus.count, 0);
        check("clear_addr", bus.out_addr, BASE_ADDR);
        bus.clear = 1'b0;
        #1;
        check("clear_in_ready", bus.in_ready, 1);

        step(1, jal, 0, 0);
        check("jal_word", bus.out_inst, 32'h001000EF);
        step(1, lui, 1, 0);
        check("lui_word", bus.out_inst, 32'h123452B7);
        step(0, idle, 1, 0);
        step(0, idle, 0, 1);

        // Back-to-back words with the memory stalled for three cycles
        step(1, addi, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, add, 0, 0);
            check("stall_inst", bus.out_inst, 32'h00500093);
            check("stall_addr", bus.out_addr, 14);
            check("stall_in_ready", bus.in_ready, 0);
        end
        step(1, add, 1, 0);
        check("post_stall_add", bus.out_inst, 32'h002081B3);
        check("post_stall_addr", bus.out_addr, 15);
        step(1, sw, 1, 0);
        check("post_stall_sw_addr", bus.out_addr, 0);
        step(0, idle, 1, 0);
        check("stall_count", bus.count, 3);

        step(1, bad_op, 1, 0);
        check("illegal_pulse", bus.illegal, 1);
        check("illegal_no_emit", bus.out_valid, 0);
        check("illegal_count", bus.count, 3);
        step(0, idle, 1, 0);
        check("illegal_one_cycle", bus.illegal, 0);

        step(1, big, 1, 0);
`ifdef IMM_RANGE_CHECK_EN
        check("big_imm_err", bus.imm_err, 1);
        check("big_no_emit", bus.out_valid, 0);
`else
        check("big_imm_err", bus.imm_err, 0);
        check("big_trunc_word", bus.out_inst, 32'h00000093);
`endif
        step(0, idle, 1, 0);
        check("big_imm_err_pulse", bus.imm_err, 0);
        step(0, idle, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset while a word is held
        step(0, idle, 0, 1);
        step(1, lui, 0, 0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_inst", bus.out_inst, 0);
        check("arst_count", bus.count, 0);
        check("arst_in_ready", bus.in_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, sw, 0, 0);
        step(0, idle, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
